// File: rtl/pipe_mem_pkg.sv
// Shared definitions for the load/store RMW memory block: size codes, FSM states,
// captured request fields and the byte-lane mask helper.
package pipe_mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       zext;
        logic [2:0] off;
    } req_t;

    // Lanes touched by an access of the given size starting at byte offset off.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/dmem_sp_ram.sv
// Single-port synchronous RAM: registered read on re, write on we, no reset.
module dmem_sp_ram #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  re,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/pipe_mem_rmw.sv
// Byte-addressed load/store front end over a word RAM; sub-word stores are done as
// read-modify-write. Define PIPE_MEM_ALIGN_CHECK_EN to reject misaligned accesses.
module pipe_mem_rmw
    import pipe_mem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_zext,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    state_t state, state_nxt;
    req_t   req_d, req_q;

    logic [DEPTH_LOG2-1:0] idx_d, idx_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [2:0]            off_raw, off_d, amask;
    logic                  accept, size_err, misalign, bad, full_st;
    logic                  unused_addr;

    logic                  ram_re, ram_we;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [DATA_W-1:0]     ram_wdata, ram_rdata;

    logic [NB-1:0]         lmask;
    logic [NB-1:0][7:0]    rd_lanes, st_lanes, mg_lanes;
    logic [DATA_W-1:0]     rshift, ld_ext;
    logic                  sbit;

    assign accept      = req_valid && req_ready;
    assign idx_d       = req_addr[DEPTH_LOG2+OFF_W-1:OFF_W];
    assign off_raw     = 3'(req_addr[OFF_W-1:0]);
    assign unused_addr = ^req_addr[31:DEPTH_LOG2+OFF_W];

    always_comb begin
        case (req_size)
            SZ_B:    amask = 3'b000;
            SZ_H:    amask = 3'b001;
            SZ_W:    amask = 3'b011;
            default: amask = 3'b111;
        endcase
    end

    assign size_err = (DATA_W == 32) && (req_size == SZ_D);
    assign misalign = |(off_raw & amask);
    assign full_st  = req_we && (req_size == ((DATA_W == 64) ? SZ_D : SZ_W));

`ifdef PIPE_MEM_ALIGN_CHECK_EN
    assign bad   = size_err || misalign;
    assign off_d = off_raw;
`else
    // Misaligned offsets are rounded down to the access size instead of faulting.
    assign bad   = size_err || (misalign && 1'b0);
    assign off_d = off_raw & ~amask;
`endif

    assign req_d = '{we: req_we, size: req_size, zext: req_zext, off: off_d};

    always_ff @(posedge clk) begin
        if (accept) begin
            req_q   <= req_d;
            idx_q   <= idx_d;
            wdata_q <= req_wdata;
        end
    end

    // Write-back word: addressed lanes take store bytes, the rest keep RAM data.
    assign lmask    = NB'(lane_mask(req_q.size, req_q.off));
    assign rd_lanes = ram_rdata;
    assign st_lanes = wdata_q << {req_q.off, 3'b000};

    for (genvar i = 0; i < NB; i++) begin : g_lane
        assign mg_lanes[i] = lmask[i] ? st_lanes[i] : rd_lanes[i];
    end

    assign rshift = ram_rdata >> {req_q.off, 3'b000};

    always_comb begin
        case (req_q.size)
            SZ_B:    sbit = rshift[7];
            SZ_H:    sbit = rshift[15];
            SZ_W:    sbit = rshift[31];
            default: sbit = rshift[DATA_W-1];
        endcase
        sbit = sbit & ~req_q.zext;
        for (int j = 0; j < DATA_W; j++)
            ld_ext[j] = (j < (8 << req_q.size)) ? rshift[j] : sbit;
    end

    assign ram_re    = accept && !bad && !full_st;
    assign ram_we    = (accept && !bad && full_st) || (state == RD && req_q.we);
    assign ram_addr  = (state == RD) ? idx_q : idx_d;
    assign ram_wdata = (state == RD) ? mg_lanes : req_wdata;

    dmem_sp_ram #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .clk   (clk),
        .re    (ram_re),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (bad || full_st) ? RESP : RD;
            RD:      state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (accept && (bad || full_st)) begin
            resp_rdata <= '0;
            resp_err   <= bad;
        end else if (state == RD) begin
            resp_rdata <= req_q.we ? '0 : ld_ext;
            resp_err   <= 1'b0;
        end
    end

endmodule

// File: doc/pipe_mem_rmw.md
PIPE_MEM_RMW -- requirements
Module: pipe_mem_rmw

Interface
REQ-001 Parameter DATA_W, default 32: RAM word width in bits; legal values 32 or 64. Byte lanes NB = DATA_W/8.
REQ-002 Parameter DEPTH_LOG2, default 8: log2 of the number of RAM words.
REQ-003 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port req_valid, input, 1: request present.
REQ-006 Port req_ready, output, 1: block can accept a request.
REQ-007 Port req_we, input, 1: 1 = store, 0 = load.
REQ-008 Port req_size, input, 2: 00 byte, 01 halfword, 10 word (32b), 11 doubleword (64b).
REQ-009 Port req_zext, input, 1: load extension; 1 = zero-extend, 0 = sign-extend.
REQ-010 Port req_addr, input, 32: byte address.
REQ-011 Port req_wdata, input, DATA_W: store data, right-aligned.
REQ-012 Port resp_valid, output, 1: one-cycle completion pulse.
REQ-013 Port resp_rdata, output, DATA_W: extended load result.
REQ-014 Port resp_err, output, 1: request rejected as an address or size error.

Function
REQ-015 A request is accepted on a rising edge where req_valid && req_ready; req_ready = (state == IDLE).
REQ-016 The FSM has states IDLE, RD, RESP. RD is entered only for loads and sub-word stores.
- IDLE -> RD on an accepted load or sub-word store.
- IDLE -> RESP on an accepted full-word store or an error.
- RD -> RESP unconditionally.
- RESP -> IDLE unconditionally.
REQ-017 The RAM word index is req_addr[DEPTH_LOG2+log2(NB)-1 : log2(NB)]; higher address bits are ignored, so addresses wrap.
REQ-018 A full-width store (size == DATA_W) writes the RAM on the accept edge; resp_valid is high in the next cycle.
REQ-019 Load timing:
- RAM read is issued on the accept edge.
- At the RD edge, the selected lane is extended per req_zext and registered into resp_rdata.
- resp_valid is high 2 cycles after accept.
REQ-020 Sub-word store timing (read-modify-write):
- RAM read is issued on the accept edge.
- At the RD edge, the word is written back with only the addressed lanes replaced by the low bytes of req_wdata.
- resp_valid is high 2 cycles after accept.
REQ-021 Request fields are captured at accept; later input changes do not affect the operation in flight.
REQ-022 Alignment error: halfword with addr[0] != 0, word with addr[1:0] != 0, or doubleword with addr[2:0] != 0.
REQ-023 Size 11 with DATA_W == 32 is a size error.
REQ-024 On an error: no RAM read or write; resp_err = 1 and resp_rdata = 0 with resp_valid one cycle after accept.
REQ-025 For stores, resp_rdata = 0.
REQ-026 resp_valid lasts exactly one cycle; there is no response back-pressure.
REQ-027 resp_rdata and resp_err hold their values until the next resp_valid.

Reset
REQ-028 rst forces state IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0.
REQ-029 Reset asserted in RD aborts the pending RMW write; writes already performed on earlier edges remain.
REQ-030 RAM contents are not reset.

Configuration
REQ-031 With macro PIPE_MEM_ALIGN_CHECK_EN defined, REQ-022/REQ-024 apply.
REQ-032 Without PIPE_MEM_ALIGN_CHECK_EN:
- Misaligned low address bits are forced to zero for the access size.
- The access proceeds normally.
- resp_err is raised only for the REQ-023 size error.

Structure
REQ-033 Shared package pipe_mem_pkg holds:
- the size encoding constants (SZ_B, SZ_H, SZ_W, SZ_D);
- the FSM state typedef;
- the lane-mask function.
REQ-034 One sub-module, dmem_sp_ram: single-port synchronous RAM with DATA_W x 2^DEPTH_LOG2 storage, 1-cycle registered read, write-enable, no reset.

Verification
REQ-035 DATA_W=32: store word 0x8899AABB at 0x10, then load byte sign-extended at 0x13 -> resp_rdata = 0xFFFFFF88, latency 2, resp_err = 0.
REQ-036 Store halfword 0x1234 at 0x12 over word 0x8899AABB, then load word at 0x10 -> 0x1234AABB; the store response arrives 2 cycles after accept.
REQ-037 Align check enabled: load word at 0x06 -> resp_err = 1, resp_rdata = 0, resp_valid 1 cycle after accept, RAM unchanged. Disabled: same request returns the word at 0x04 with resp_err = 0.
REQ-038 DATA_W=32, req_size = 11 -> resp_err = 1 in both configurations. DATA_W=64: store doubleword 0x0123456789ABCDEF at 0x08, then load halfword zero-extended at 0x0E -> 0x0000000000000123.
REQ-039 Store byte 0x55 at 0x20 (word initially 0); assert rst during RD -> after reset, a word load at 0x20 returns 0x00000000 and req_ready = 1 immediately after reset.
REQ-040 Address wrap: DEPTH_LOG2=8, DATA_W=32: store word 0xDEADBEEF at 0x400, then load word at 0x000 -> 0xDEADBEEF.
